// File: rtl/launcher_pkg.sv
// rtl/launcher_pkg.sv - shared state encoding and defaults for the program launcher
package launcher_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        RUN    = 3'd2,
        REPORT = 3'd3,
        FINISH = 3'd4
    } launchState_t;

    localparam int DEFAULT_TIMEOUT      = 20000;
    localparam int DEFAULT_START_CYCLES = 2;

endpackage

// File: rtl/cycle_timer.sv
// rtl/cycle_timer.sv - clearable up-counter flagging the cycle whose increment reaches LIMIT
module cycle_timer #(
    parameter int CYC_W = 16,
    parameter int LIMIT = 20000
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             clear,
    input  logic             enable,
    output logic [CYC_W-1:0] count,
    output logic             hit_limit
);

    // Asserted while count+1 equals LIMIT, so the owner can act on the same edge.
    assign hit_limit = (count == CYC_W'(LIMIT - 1));

    always_ff @(posedge Clk) begin
        if (Reset || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CYC_W'(1);
        end
    end

endmodule

// File: rtl/prog_launcher.sv
// rtl/prog_launcher.sv - sequences Reset/Start to the core for NUM_PROGS programs and reports cycle counts
module prog_launcher
    import launcher_pkg::*;
#(
    parameter int NUM_PROGS    = 3,
    parameter int CYC_W        = 16,
    parameter int TIMEOUT      = DEFAULT_TIMEOUT,
    parameter int START_CYCLES = DEFAULT_START_CYCLES,
    localparam int PW          = (NUM_PROGS > 1) ? $clog2(NUM_PROGS) : 1
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Go,
    input  logic             DutAck,
    output logic             DutReset,
    output logic             DutStart,
    output logic [PW-1:0]    ProgIdx,
    output logic [CYC_W-1:0] CycleCount,
    output logic             CountValid,
    output logic             TimedOut,
    output logic             Busy,
    output logic             Done
);

    localparam int SW = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;

    if (TIMEOUT < 1 || (TIMEOUT >> CYC_W) != 0) begin : gBadTimeout
        $error("prog_launcher: TIMEOUT must lie in 1 .. 2**CYC_W-1");
    end

    launchState_t     state;
    launchState_t     nextState;
    logic [SW-1:0]    startCnt;
    logic [CYC_W-1:0] runCount;
    logic             hitLimit;
    logic             startLast;
    logic             lastProg;
    logic             inRun;

    assign startLast = (startCnt == SW'(START_CYCLES - 1));
    assign lastProg  = (ProgIdx == PW'(NUM_PROGS - 1));
    assign inRun     = (state == RUN);

    cycle_timer #(
        .CYC_W (CYC_W),
        .LIMIT (TIMEOUT)
    ) runTimer (
        .Clk       (Clk),
        .Reset     (Reset),
        .clear     (!inRun),
        .enable    (inRun),
        .count     (runCount),
        .hit_limit (hitLimit)
    );

    // Pin outputs depend on the registered state only, never on inputs.
    always_comb begin
        nextState = state;
        DutReset  = 1'b0;
        DutStart  = 1'b0;
        Busy      = 1'b0;
        Done      = 1'b0;
        case (state)
            IDLE: begin
                DutReset = 1'b1;
                if (Go) nextState = START;
            end
            START: begin
                DutStart = 1'b1;
                Busy     = 1'b1;
                if (startLast) nextState = RUN;
            end
            RUN: begin
                Busy = 1'b1;
                if (DutAck || hitLimit) nextState = REPORT;
            end
            REPORT: begin
                Busy      = 1'b1;
                nextState = lastProg ? FINISH : START;
            end
            FINISH: begin
                Done = 1'b1;
                if (Go) nextState = START;
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state      <= IDLE;
            startCnt   <= '0;
            ProgIdx    <= '0;
            CycleCount <= '0;
            CountValid <= 1'b0;
            TimedOut   <= 1'b0;
        end else begin
            state      <= nextState;
            CountValid <= 1'b0;
            case (state)
                IDLE, FINISH: begin
                    if (Go) begin
                        ProgIdx  <= '0;
                        TimedOut <= 1'b0;
                    end
                end
                START: startCnt <= startLast ? '0 : startCnt + SW'(1);
                RUN: begin
                    // Ack wins over a coincident timeout and is not flagged.
                    if (DutAck) begin
                        CycleCount <= runCount + CYC_W'(1);
                        CountValid <= 1'b1;
                    end else if (hitLimit) begin
                        CycleCount <= CYC_W'(TIMEOUT);
                        CountValid <= 1'b1;
                        TimedOut   <= 1'b1;
                    end
                end
                REPORT: begin
                    if (!lastProg) ProgIdx <= ProgIdx + PW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/prog_launcher.md
Name: prog_launcher

Overview:
- Upstream harness-side sequencer for the 9-bit processor core. Drives the core's Reset/Start pins and runs NUM_PROGS programs back-to-back.
- For each program it waits for the core's Ack, measures execution cycles and reports them. A per-program timeout prevents hangs.
- Sits between the testbench/host (Go) and the processor top level (DutReset, DutStart, DutAck).

Parameters:
NUM_PROGS, 3, number of programs run per Go sequence (≥1)
CYC_W, 16, width of cycle counter and CycleCount
TIMEOUT, 20000, max RUN cycles per program before abort (< 2^CYC_W)
START_CYCLES, 2, cycles DutStart is held high per program (≥1)

Ports:
Clk  in  1  clock, posedge
Reset  in  1  synchronous, active-high reset
Go  in  1  level; starts a sequence when sampled high in IDLE or FINISH
DutAck  in  1  done flag from processor
DutReset  out  1  reset to processor
DutStart  out  1  start to processor
ProgIdx  out  PW=max(1,$clog2(NUM_PROGS))  index of current/last program
CycleCount  out  CYC_W  cycles of last completed program
CountValid  out  1  one-cycle pulse, CycleCount updated
TimedOut  out  1  sticky: some program in this sequence hit TIMEOUT
Busy  out  1  sequence in progress
Done  out  1  sequence complete

Behaviour:
- One clock (Clk); Reset is synchronous, active-high. Reset overrides everything, including mid-sequence.
- Reset values: state IDLE, DutReset=1, DutStart=0, ProgIdx=0, CycleCount=0, CountValid=0, TimedOut=0, Busy=0, Done=0, internal counters=0.
- DutReset, DutStart, Busy and Done are decoded from the registered state only. They are glitch-free and never combinational from inputs.
- FSM states:
  - IDLE: DutReset=1, Busy=0, Done=0. When Go=1: ProgIdx<=0, TimedOut<=0, then go to START.
  - START: DutReset=0, DutStart=1, Busy=1. Remains for exactly START_CYCLES cycles, counted by the start counter. Then go to RUN with cycle counter<=0. DutAck is ignored in START.
  - RUN: DutStart=0, Busy=1. Each cycle: cnt<=cnt+1.
    - If DutAck=1: CycleCount<=cnt+1, CountValid<=1, then go to REPORT.
    - Else if cnt+1==TIMEOUT: CycleCount<=TIMEOUT, CountValid<=1, TimedOut<=1, then go to REPORT.
    - Ack has priority over timeout in the same cycle; that case is not flagged as TimedOut.
  - REPORT (1 cycle): Busy=1, CountValid back to 0.
    - If ProgIdx==NUM_PROGS-1, go to FINISH.
    - Else ProgIdx<=ProgIdx+1 and go to START.
  - FINISH: Busy=0, Done=1, DutReset=0. ProgIdx, CycleCount and TimedOut hold.
    - Go=1 restarts exactly as from IDLE (ProgIdx<=0, TimedOut<=0, go to START).
    - Go=0 holds in FINISH.
- Latency:
  - Go sampled high at edge t gives DutStart=1 from t+1 through t+START_CYCLES.
  - RUN begins at t+START_CYCLES+1.
  - Ack first seen in the k-th RUN cycle gives CycleCount=k, with CountValid high in the following cycle.
- Go is ignored in START/RUN/REPORT; it is not queued.
- CycleCount never wraps: TIMEOUT < 2^CYC_W is checked by an elaboration-time assertion.
- NUM_PROGS=1: REPORT goes directly to FINISH, and ProgIdx stays 0.

Decomposition:
- launcher_pkg: state enum (IDLE, START, RUN, REPORT, FINISH) as a 3-bit typedef, plus the default localparams for TIMEOUT and START_CYCLES.
- One sub-module: cycle_timer.
  - Inputs: clear, enable.
  - Outputs: count and hit_limit, parameterised by CYC_W and LIMIT.
  - Used for the RUN counter.
- The START counter stays inline.

Test Plan (NUM_PROGS=3, START_CYCLES=2, TIMEOUT=50):
1. Reset held 3 cycles, then released with Go=0 -> DutReset=1, DutStart=0, all other outputs 0, state stays IDLE.
2. Go pulsed 1 cycle; model asserts DutAck on RUN cycle 10, 20, 30 for programs 0–1–2 -> per program DutStart high exactly 2 cycles; CountValid pulses with CycleCount=10, 20, 30 and ProgIdx=0, 1, 2; then Done=1, Busy=0, TimedOut=0.
3. Program 1 never asserts Ack -> CycleCount=50, TimedOut=1 and stays 1; program 2 still runs with Ack at cycle 5 and reports CycleCount=5; Done=1.
4. DutAck held high through START and into RUN -> Ack ignored during START; CycleCount=1 reported for each program.
5. Ack asserted on exactly RUN cycle 50 -> CycleCount=50, TimedOut stays 0.
6. Reset asserted mid-RUN of program 1 -> next cycle all outputs at reset values; a later Go restarts cleanly at ProgIdx=0. Separately, Go from FINISH restarts the sequence and clears TimedOut.
